// File: rtl/dot_product_accumulator_pkg.sv
// Shared types and widths for the dot-product accumulator slice.
package dot_product_accumulator_pkg;

   localparam int unsigned DATA_WIDTH        = 16;
   localparam int unsigned PROD_WIDTH        = 2 * DATA_WIDTH;
   localparam int unsigned ACC_WIDTH         = 48;
   localparam int unsigned FRAC_BITS_DEFAULT = 8;

   typedef enum logic [1:0] {
      ST_ACC   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/dot_product_accumulator_if.sv
// Term-beat input stream and result output stream of the accumulator.
interface dot_product_accumulator_if;
   import dot_product_accumulator_pkg::*;

   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_x;
   logic [DATA_WIDTH-1:0] in_w;
   logic                  in_last;
   logic                  out_valid;
   logic                  out_ready;
   logic [ACC_WIDTH-1:0]  out_sum;
   logic                  out_overrun;

   modport master (
      output in_valid, in_x, in_w, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_overrun
   );

   modport slave (
      input  in_valid, in_x, in_w, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_overrun
   );

endinterface

// File: rtl/dot_product_accumulator_mac_product_stage.sv
// First pipeline stage: registered signed 16x16 multiply with a valid flag.
module mac_product_stage
   import dot_product_accumulator_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic signed [DATA_WIDTH-1:0] x,
   input  logic signed [DATA_WIDTH-1:0] w,
   output logic signed [PROD_WIDTH-1:0] product,
   output logic                         product_valid
);

   // Capture the product of an accepted beat; valid tracks acceptance one cycle later.
   always_ff @(posedge clk) begin
      if (rst) begin
         product       <= '0;
         product_valid <= 1'b0;
      end else begin
         product_valid <= en;
         if (en) begin
            product <= PROD_WIDTH'(x) * PROD_WIDTH'(w);
         end
      end
   end

endmodule

// File: rtl/dot_product_accumulator.sv
// Streaming dot-product accumulator: sums x*w over a frame of beats and
// presents the 48-bit Q16 result with a ready/valid handshake.
// Optional macro DOT_PRODUCT_BIAS_EN adds a Q8 bias port folded in at flush.
module dot_product_accumulator
   import dot_product_accumulator_pkg::*;
#(
   parameter int unsigned MAX_TERMS = 256,
   parameter int unsigned FRAC_BITS = FRAC_BITS_DEFAULT
) (
   input  logic                         clk,
   input  logic                         rst,
`ifdef DOT_PRODUCT_BIAS_EN
   input  logic signed [DATA_WIDTH-1:0] bias,
`endif
   dot_product_accumulator_if.slave     bus
);

   localparam int unsigned CNT_W = $clog2(MAX_TERMS) + 1;

   // Frame length bound keeps the worst-case sum inside the 48-bit accumulator.
   if (MAX_TERMS < 1 || MAX_TERMS > 65536) begin : g_max_terms_check
      $error("MAX_TERMS must lie in 1..65536");
   end

   // The binary point must sit inside the operand word.
   if (FRAC_BITS >= DATA_WIDTH) begin : g_frac_bits_check
      $error("FRAC_BITS must be smaller than DATA_WIDTH");
   end

   state_t                         state;
   logic                           in_ready_q;
   logic                           out_valid_q;
   logic                           overrun_q;
   logic [ACC_WIDTH-1:0]           acc;
   logic [CNT_W-1:0]               cnt;
   logic [CNT_W-1:0]               cnt_inc;
   logic                           accept;
   logic                           at_limit;
   logic signed [PROD_WIDTH-1:0]   prod;
   logic                           prod_vld;
   logic [ACC_WIDTH-1:0]           prod_ext;
   logic [ACC_WIDTH-1:0]           bias_ext;

   assign accept   = bus.in_valid && in_ready_q;
   assign cnt_inc  = cnt + CNT_W'(1);
   assign at_limit = (cnt_inc == CNT_W'(MAX_TERMS));

   mac_product_stage u_mac (
      .clk           (clk),
      .rst           (rst),
      .en            (accept),
      .x             (bus.in_x),
      .w             (bus.in_w),
      .product       (prod),
      .product_valid (prod_vld)
   );

   // Sign-extend the pending product (zero when nothing is pending) and the bias term.
   always_comb begin
      prod_ext = '0;
      bias_ext = '0;
      if (prod_vld) begin
         prod_ext = ACC_WIDTH'(prod);
      end
`ifdef DOT_PRODUCT_BIAS_EN
      bias_ext = ACC_WIDTH'(bias) <<< FRAC_BITS;
`endif
   end

   // Frame control FSM with accumulator, beat counter and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_ACC;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
         acc         <= '0;
         cnt         <= '0;
      end else begin
         case (state)
            ST_ACC: begin
               acc <= acc + prod_ext;
               if (accept) begin
                  cnt <= cnt_inc;
                  if (bus.in_last || at_limit) begin
                     state      <= ST_FLUSH;
                     in_ready_q <= 1'b0;
                     overrun_q  <= !bus.in_last && at_limit;
                  end
               end
            end
            ST_FLUSH: begin
               acc         <= acc + prod_ext + bias_ext;
               state       <= ST_DONE;
               out_valid_q <= 1'b1;
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  state       <= ST_ACC;
                  in_ready_q  <= 1'b1;
                  out_valid_q <= 1'b0;
                  overrun_q   <= 1'b0;
                  acc         <= '0;
                  cnt         <= '0;
               end
            end
            default: begin
               state       <= ST_ACC;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               overrun_q   <= 1'b0;
               acc         <= '0;
               cnt         <= '0;
            end
         endcase
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_sum     = acc;
   assign bus.out_overrun = overrun_q;

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Self-checking bench for dot_product_accumulator: vector table, hand-written
// corner sequences and random frames against an arithmetic reference model.
module tb_dot_product_accumulator;

   localparam int unsigned MAX_TERMS = 4;
`ifdef DOT_PRODUCT_BIAS_EN
   localparam bit BIAS_EN = 1'b1;
`else
   localparam bit BIAS_EN = 1'b0;
`endif

   typedef struct {
      logic [15:0] x;
      logic [15:0] w;
      logic        last;
   } beat_t;

   typedef struct {
      string       name;
      int          n;
      logic [15:0] x;
      logic [15:0] w;
      logic        last;
      logic [47:0] exp_sum;
      logic        exp_ovr;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] bias_val = '0;
   int          n_total = 0;
   int          n_pass  = 0;
   beat_t       frame_q[$];

   dot_product_accumulator_if bus ();

   dot_product_accumulator #(.MAX_TERMS(MAX_TERMS), .FRAC_BITS(8)) dut (
      .clk  (clk),
      .rst  (rst),
`ifdef DOT_PRODUCT_BIAS_EN
      .bias (bias_val),
`endif
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic build_uniform(input int n, input logic [15:0] x, input logic [15:0] w,
                                input logic last);
      beat_t b;
      frame_q.delete();
      for (int i = 0; i < n; i++) begin
         b.x = x;
         b.w = w;
         b.last = last && (i == n - 1);
         frame_q.push_back(b);
      end
   endtask

   // Reference: plain signed arithmetic over the frame, reduced modulo 2^48.
   function automatic logic [47:0] model_sum(input logic [15:0] bias_in);
      longint  s = 0;
      shortint xs;
      shortint ws;
      shortint bs;
      logic [63:0] t;
      foreach (frame_q[i]) begin
         xs = frame_q[i].x;
         ws = frame_q[i].w;
         s += longint'(xs) * longint'(ws);
      end
      if (BIAS_EN) begin
         bs = bias_in;
         s += longint'(bs) * 256;
      end
      t = s;
      return t[47:0];
   endfunction

   // Drive the queued beats (optionally with idle gaps), then collect and release the result.
   task automatic run_frame(input string name, input logic [47:0] exp_sum, input logic exp_ovr,
                            input bit gaps, input int hold);
      int idx = 0;
      int guard = 0;
      int lat = 0;
      while (idx < frame_q.size() && guard < 1000) begin
         @(negedge clk);
         guard++;
         if (gaps && $urandom_range(0, 3) == 0) begin
            bus.in_valid = 1'b0;
            bus.in_x     = 16'($urandom);
            bus.in_w     = 16'($urandom);
            bus.in_last  = 1'($urandom);
         end else begin
            bus.in_valid = 1'b1;
            bus.in_x     = frame_q[idx].x;
            bus.in_w     = frame_q[idx].w;
            bus.in_last  = frame_q[idx].last;
            if (bus.in_ready) idx++;
         end
      end
      check({name, " beats accepted"}, 64'(idx), 64'(frame_q.size()));
      do begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         lat++;
      end while (!bus.out_valid && lat < 20);
      check({name, " latency"}, 64'(lat), 64'd2);
      for (int i = 0; i < hold; i++) begin
         bus.in_valid = 1'b1;
         bus.in_x     = 16'($urandom);
         bus.in_w     = 16'($urandom);
         bus.in_last  = 1'($urandom);
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      check({name, " sum"}, 64'(bus.out_sum), 64'(exp_sum));
      check({name, " overrun"}, 64'(bus.out_overrun), 64'(exp_ovr));
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check({name, " ready after release"}, 64'(bus.in_ready), 64'd1);
   endtask

   vec_t vecs[6];

   initial begin
      logic [47:0] held;
      bit          ready_low;
      bit          stable;
      int          n;
      logic        last;
      beat_t       b;

      vecs[0] = '{"three_beats",  3, 16'h0100, 16'h0200, 1'b1, 48'h000000060000, 1'b0};
      vecs[1] = '{"neg_single",   1, 16'hFF00, 16'h0100, 1'b1, 48'hFFFFFFFF0000, 1'b0};
      vecs[2] = '{"overrun",      4, 16'h0100, 16'h0100, 1'b0, 48'h000000040000, 1'b1};
      vecs[3] = '{"last_at_max",  4, 16'h0100, 16'h0100, 1'b1, 48'h000000040000, 1'b0};
      vecs[4] = '{"min_squared",  2, 16'h8000, 16'h8000, 1'b1, 48'h000080000000, 1'b0};
      vecs[5] = '{"max_by_min",   1, 16'h7FFF, 16'h8000, 1'b1, 48'hFFFFC0008000, 1'b0};

      bus.in_valid  = 1'b0;
      bus.in_x      = '0;
      bus.in_w      = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset in_ready", 64'(bus.in_ready), 64'd1);
      check("reset out_valid", 64'(bus.out_valid), 64'd0);
      check("reset out_sum", 64'(bus.out_sum), 64'd0);
      check("reset out_overrun", 64'(bus.out_overrun), 64'd0);

      for (int i = 0; i < 6; i++) begin
         build_uniform(vecs[i].n, vecs[i].x, vecs[i].w, vecs[i].last);
         run_frame(vecs[i].name, vecs[i].exp_sum, vecs[i].exp_ovr, 1'b0, 0);
      end

      // Result held while the consumer stalls and the producer keeps pushing.
      build_uniform(2, 16'h0300, 16'h0100, 1'b1);
      run_frame("hold_setup", 48'h000000060000, 1'b0, 1'b0, 0);
      build_uniform(1, 16'h0100, 16'h0100, 1'b1);
      begin
         @(negedge clk);
         bus.in_valid = 1'b1; bus.in_x = 16'h0100; bus.in_w = 16'h0100; bus.in_last = 1'b1;
         @(negedge clk);
         bus.in_valid = 1'b1; bus.in_x = 16'h7777; bus.in_w = 16'h7777;
         @(negedge clk);
         check("hold out_valid", 64'(bus.out_valid), 64'd1);
         held = bus.out_sum;
         ready_low = 1'b1;
         stable = 1'b1;
         for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.in_ready) ready_low = 1'b0;
            if (bus.out_sum !== held || !bus.out_valid) stable = 1'b0;
         end
         check("hold sum value", 64'(held), 64'h10000);
         check("hold sum stable", 64'(stable), 64'd1);
         check("hold in_ready low", 64'(ready_low), 64'd1);
         bus.in_valid  = 1'b0;
         bus.out_ready = 1'b1;
         @(negedge clk);
         bus.out_ready = 1'b0;
         check("hold ready after release", 64'(bus.in_ready), 64'd1);
         check("hold out_valid dropped", 64'(bus.out_valid), 64'd0);
      end
      build_uniform(1, 16'h0100, 16'h0100, 1'b1);
      run_frame("after_hold", 48'h000000010000, 1'b0, 1'b0, 0);

      // Reset in the middle of a frame discards the partial sum.
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1; bus.in_x = 16'h0500; bus.in_w = 16'h0100; bus.in_last = 1'b0;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midreset out_sum", 64'(bus.out_sum), 64'd0);
      check("midreset in_ready", 64'(bus.in_ready), 64'd1);
      build_uniform(1, 16'h0200, 16'h0100, 1'b1);
      run_frame("after_midreset", 48'h000000020000, 1'b0, 1'b0, 0);

      // Reset while a result is waiting in DONE.
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_x = 16'h0100; bus.in_w = 16'h0100; bus.in_last = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("done before reset", 64'(bus.out_valid), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("done reset out_valid", 64'(bus.out_valid), 64'd0);
      check("done reset out_sum", 64'(bus.out_sum), 64'd0);
      check("done reset in_ready", 64'(bus.in_ready), 64'd1);

`ifdef DOT_PRODUCT_BIAS_EN
      bias_val = 16'h0080;
      build_uniform(1, 16'h0100, 16'h0100, 1'b1);
      run_frame("bias", 48'h000000018000, 1'b0, 1'b0, 0);
`endif

      for (int f = 0; f < 40; f++) begin
         n = $urandom_range(1, MAX_TERMS);
         last = (n < MAX_TERMS) ? 1'b1 : 1'($urandom);
         frame_q.delete();
         for (int i = 0; i < n; i++) begin
            b.x = 16'($urandom);
            b.w = 16'($urandom);
            b.last = last && (i == n - 1);
            frame_q.push_back(b);
         end
         if (BIAS_EN) bias_val = 16'($urandom);
         run_frame($sformatf("rand%0d", f), model_sum(bias_val),
                   (n == MAX_TERMS) && !last, 1'b1, $urandom_range(0, 3));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/dot_product_accumulator.md
DOT_PRODUCT_ACCUMULATOR -- requirements
Module: dot_product_accumulator

Interface
REQ-001 Parameter MAX_TERMS, default 256: maximum terms per frame before forced termination.
REQ-002 Parameter FRAC_BITS, default 8: fractional bits of in_x/in_w (signed Q7.8).
REQ-003 clk  input  1  sole clock, all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  term beat present.
REQ-006 in_ready  output  1  block accepts beat this cycle.
REQ-007 in_x  input  16  signed Q8 input activation.
REQ-008 in_w  input  16  signed Q8 weight.
REQ-009 in_last  input  1  beat is final term of frame.
REQ-010 out_valid  output  1  out_sum holds a completed dot product.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 out_sum  output  48  signed Q16 sum of products; format consumed directly by the activation stage.
REQ-013 out_overrun  output  1  frame terminated by MAX_TERMS, not in_last; valid with out_valid.

Function
REQ-014 Beat accepted iff in_valid && in_ready on a rising edge.
REQ-015 Stage 1 registers product in_x*in_w as 32-bit signed and a product-valid flag; stage 2 adds sign-extended 48-bit product to accumulator.
REQ-016 FSM states: ACC, FLUSH, DONE.
REQ-017 ACC: in_ready=1; on accepted beat with in_last, or beat count reaching MAX_TERMS, go to FLUSH; otherwise stay.
REQ-018 FLUSH: in_ready=0; final pending product added; go to DONE next cycle.
REQ-019 DONE: in_ready=0, out_valid=1, out_sum and out_overrun held stable until out_ready=1.
REQ-020 DONE with out_ready=1: accumulator, beat counter, out_overrun cleared; next state ACC; in_ready=1 the following cycle.
REQ-021 Latency: final beat accepted cycle t -> out_valid=1 at cycle t+2.
REQ-022 Accumulator arithmetic wraps modulo 2^48; no saturation (MAX_TERMS*2^30 must fit; implementation asserts MAX_TERMS<=2^16).
REQ-023 Beat counter width clog2(MAX_TERMS)+1; out_overrun=1 only when MAX_TERMS-th beat has in_last=0.
REQ-024 in_valid while in_ready=0: beat ignored, no state change.
REQ-025 in_x, in_w, in_last don't-care when not accepted.

Reset
REQ-026 rst=1 at any state (incl. mid-frame or DONE): next state ACC, accumulator 0, product pipeline flushed, counter 0.
REQ-027 Reset output values: in_ready=1 after release, out_valid=0, out_sum=0, out_overrun=0.

Configuration
REQ-028 Macro DOT_PRODUCT_BIAS_EN defined: extra input port bias (16-bit signed Q8); sampled in FLUSH and added as bias<<FRAC_BITS (sign-extended 48-bit) with the final product.
REQ-029 Macro undefined: bias port absent; no bias term; out_sum is pure sum of products.

Structure
REQ-030 Shared package holds FRAC_BITS default, ACC_WIDTH=48, DATA_WIDTH=16, FSM state enum.
REQ-031 One sub-module natural: mac_product_stage (registered signed 16x16 multiply plus valid flag).

Verification
REQ-032 Three beats x=0x0100, w=0x0200, last on third -> out_valid two cycles after third beat, out_sum=0x000000060000, out_overrun=0.
REQ-033 One beat x=0xFF00, w=0x0100, in_last=1 -> out_sum=0xFFFFFFFF0000.
REQ-034 Result held with out_ready=0 for 5 cycles while in_valid=1 -> out_sum stable, in_ready=0, no beats absorbed; out_ready=1 -> in_ready=1 next cycle.
REQ-035 MAX_TERMS=4, four beats x=w=0x0100, in_last=0 -> out_sum=0x000000040000, out_overrun=1.
REQ-036 rst asserted after two accepted beats, then one beat x=0x0200, w=0x0100, last -> out_sum=0x000000020000 (pre-reset terms lost).
REQ-037 DOT_PRODUCT_BIAS_EN, bias=0x0080, one beat x=w=0x0100 last -> out_sum=0x000000018000.
